// File: rtl/conversor_display_pkg.sv
// Shared constants and types for the binary-to-seven-segment RAM writer.
// Segment patterns are active-low, bit6..0 = a,b,c,d,e,f,g.
package conversor_display_pkg;

    localparam int NIB_W = 4;

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index 9 first: SEG_TABLE[d] is the pattern of digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000,
        7'b0100100, 7'b1001100, 7'b0000110, 7'b0010010,
        7'b1001111, 7'b0000001
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/conversor_display_bcd_para_7seg.sv
// BCD nibble to active-low seven-segment decoder.
// Non-decimal codes 10..15 show a dash.
module bcd_para_7seg
    import conversor_display_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0:    seg = SEG_TABLE[0];
            4'd1:    seg = SEG_TABLE[1];
            4'd2:    seg = SEG_TABLE[2];
            4'd3:    seg = SEG_TABLE[3];
            4'd4:    seg = SEG_TABLE[4];
            4'd5:    seg = SEG_TABLE[5];
            4'd6:    seg = SEG_TABLE[6];
            4'd7:    seg = SEG_TABLE[7];
            4'd8:    seg = SEG_TABLE[8];
            4'd9:    seg = SEG_TABLE[9];
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/conversor_display.sv
// Serial double-dabble converter writing one seven-segment digit
// per cycle into a single RAM row, most significant digit at column 0.
module conversor_display
    import conversor_display_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int VALUE_W  = 10,
    parameter int ADDR_W   = 11,
    parameter int LINHA    = 0,
    parameter int LZ_BLANK = 1
) (
    input  logic               clock,
    input  logic               resetCPU,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    output logic               ready,
    output logic               done,
    output logic               overflow,
    output logic [6:0]         data,
    output logic [ADDR_W-1:0]  end_linha,
    output logic [ADDR_W-1:0]  end_coluna,
    output logic               write
);

    localparam int BCD_W = NIB_W * DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);

    state_t             state;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [VALUE_W-1:0] bin;
    logic [CNT_W-1:0]   bit_cnt;
    logic [NIB_W-1:0]   sel_nib;
    logic               sel_blank;
    logic               above;
    logic [6:0]         seg;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*NIB_W +: NIB_W] >= 4'd5)
                bcd_adj[i*NIB_W +: NIB_W] = bcd[i*NIB_W +: NIB_W] + 4'd3;
        end
    end

    always_ff @(posedge clock or posedge resetCPU) begin
        if (resetCPU) begin
            state      <= ST_IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            write      <= 1'b0;
            end_coluna <= '0;
            bcd        <= '0;
            bin        <= '0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ready      <= 1'b0;
                        end_coluna <= '0;
                        bit_cnt    <= '0;
                        bin        <= value;
                        // Out-of-range values load code 10 into every
                        // nibble, which the decoder shows as a dash.
                        if (64'(value) > MAX_VAL) begin
                            overflow <= 1'b1;
                            bcd      <= {DIGITS{NIB_W'(10)}};
                            write    <= 1'b1;
                            state    <= ST_WRITE;
                        end else begin
                            overflow <= 1'b0;
                            bcd      <= '0;
                            state    <= ST_CONVERT;
                        end
                    end
                end
                ST_CONVERT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    bit_cnt    <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(VALUE_W - 1)) begin
                        write <= 1'b1;
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (end_coluna == ADDR_W'(DIGITS - 1)) begin
                        write <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        end_coluna <= end_coluna + 1'b1;
                    end
                end
                ST_DONE: begin
                    done       <= 1'b0;
                    ready      <= 1'b1;
                    end_coluna <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A zero is blank while every more significant nibble is zero too.
    always_comb begin
        sel_nib   = '0;
        sel_blank = 1'b0;
        above     = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (end_coluna == ADDR_W'(k)) begin
                sel_nib   = bcd[(DIGITS-1-k)*NIB_W +: NIB_W];
                sel_blank = (LZ_BLANK != 0) && above &&
                            (sel_nib == '0) && (k != DIGITS - 1);
            end
            if (bcd[(DIGITS-1-k)*NIB_W +: NIB_W] != '0)
                above = 1'b0;
        end
    end

    bcd_para_7seg u_dec (
        .nib (sel_nib),
        .seg (seg)
    );

    assign data      = (write && !sel_blank) ? seg : SEG_BLANK;
    assign end_linha = ADDR_W'(LINHA);

endmodule
